lut_eval: RTL and testbench

Parametrised, programmable N-input boolean function evaluator with N_FUNC independent channels. Each channel stores a 2^N_IN-entry truth table, loaded at runtime, and evaluates input vectors through a registered valid/ready stage. A sweep engine enumerates every input combination and counts the minterms of each channel. The block replaces fixed single-function minterm/mux logic in the combinational-function library.

---
 rtl/lut_eval_if.sv | 29 ++
 rtl/lut_eval.sv | 72 +++++++
 tb/tb_lut_eval.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_eval_if.sv
// lut_eval_if: configuration, evaluation handshake and sweep signals of lut_eval
interface lut_eval_if #(
    parameter int N_IN   = 3,
    parameter int N_FUNC = 2
);
    localparam int T  = 1 << N_IN;
    localparam int FW = N_FUNC > 1 ? $clog2(N_FUNC) : 1;
    logic                         cfg_we;
    logic [FW-1:0]                cfg_func;
    logic [T-1:0]                 cfg_table;
    logic                         in_valid;
    logic                         in_ready;
    logic [N_IN-1:0]              in_vec;
    logic                         out_valid;
    logic                         out_ready;
    logic [N_FUNC-1:0]            out_f;
    logic                         sweep_start;
    logic                         busy;
    logic                         sweep_done;
    logic [N_FUNC*(N_IN+1)-1:0]   sweep_count;
    modport master (
        output cfg_we, cfg_func, cfg_table, in_valid, in_vec, out_ready, sweep_start,
        input  in_ready, out_valid, out_f, busy, sweep_done, sweep_count
    );
    modport slave (
        input  cfg_we, cfg_func, cfg_table, in_valid, in_vec, out_ready, sweep_start,
        output in_ready, out_valid, out_f, busy, sweep_done, sweep_count
    );
endinterface

// File: rtl/lut_eval.sv
// lut_eval: runtime-programmable truth-table evaluator with a minterm-counting sweep
module lut_eval #(
    parameter int N_IN   = 3,
    parameter int N_FUNC = 2
) (
    input logic       clk,
    input logic       rst,
    lut_eval_if.slave bus
);
    localparam int T  = 1 << N_IN;
    localparam int CW = N_IN + 1;
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
    state_t                    state_q, state_d;
    logic [N_FUNC-1:0][T-1:0]  tbl_q, tbl_d;
    logic [N_FUNC-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]           idx_q, idx_d;
    logic                      out_valid_q, out_valid_d;
    logic [N_FUNC-1:0]         out_f_q, out_f_d;
    logic                      in_ready;
    logic                      accept;

    assign in_ready        = state_q == IDLE && !bus.sweep_start && (!out_valid_q || bus.out_ready);
    assign accept          = bus.in_valid && in_ready;
    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_f       = out_f_q;
    assign bus.busy        = state_q == SWEEP;
    assign bus.sweep_done  = state_q == DONE;
    assign bus.sweep_count = cnt_q;

    // table writes; out-of-range channels never match, and the sweep freezes the tables
    always_comb begin
        tbl_d = tbl_q;
        for (int k = 0; k < N_FUNC; k++)
            if (bus.cfg_we && state_q != SWEEP && int'(bus.cfg_func) == k) tbl_d[k] = bus.cfg_table;
    end

    // result register: load on accept (old table), drop valid once consumed
    always_comb begin
        out_valid_d = accept || (out_valid_q && !bus.out_ready);
        for (int k = 0; k < N_FUNC; k++) out_f_d[k] = accept ? tbl_q[k][bus.in_vec] : out_f_q[k];
    end

    // sweep FSM: walk idx over every table entry, accumulating each channel's minterms
    always_comb begin
        state_d = state_q == IDLE  ? (bus.sweep_start ? SWEEP : IDLE) :
                  state_q == SWEEP ? (idx_q == '1 ? DONE : SWEEP) : IDLE;
        idx_d   = state_q == SWEEP ? idx_q + 1'b1 : '0;
        cnt_d   = state_q == IDLE && bus.sweep_start ? '0 : cnt_q;
        for (int k = 0; k < N_FUNC; k++)
            if (state_q == SWEEP) cnt_d[k] = cnt_q[k] + CW'(tbl_q[k][idx_q]);
    end

    // state registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tbl_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_f_q     <= '0;
        end else begin
            state_q     <= state_d;
            tbl_q       <= tbl_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_f_q     <= out_f_d;
        end
    end
endmodule

// File: tb/tb_lut_eval.sv
// tb_lut_eval: scoreboard bench for lut_eval with a cycle-level behavioural model
module tb_lut_eval;
    localparam int NI = 3;
    localparam int NF = 3;
    localparam int T  = 8;
    localparam int CW = 4;

    logic clk = 0;
    logic rst = 0;
    always #5 clk = ~clk;

    lut_eval_if #(.N_IN(NI), .N_FUNC(NF)) m ();
    lut_eval_if #(.N_IN(1),  .N_FUNC(1))  p ();
    lut_eval_if #(.N_IN(5),  .N_FUNC(4))  q ();
    lut_eval #(.N_IN(NI), .N_FUNC(NF)) dut  (.clk(clk), .rst(rst), .bus(m.slave));
    lut_eval #(.N_IN(1),  .N_FUNC(1))  dut1 (.clk(clk), .rst(rst), .bus(p.slave));
    lut_eval #(.N_IN(5),  .N_FUNC(4))  dut5 (.clk(clk), .rst(rst), .bus(q.slave));

    int n_cmp = 0;
    int n_bad = 0;
    logic [NF-1:0]    exp_q[$];
    logic [T-1:0]     tbl[NF];
    bit               mv;
    int               sw;
    bit               dn;
    logic [NF*CW-1:0] sc;
    logic [NF-1:0]    last_f;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NF-1:0] eval_ref(logic [NI-1:0] v);
        logic [NF-1:0] r;
        for (int k = 0; k < NF; k++) r[k] = tbl[k][v];
        return r;
    endfunction

    function automatic logic [NF*CW-1:0] counts_ref();
        logic [NF*CW-1:0] r = '0;
        for (int k = 0; k < NF; k++) r[k*CW +: CW] = CW'($countones(tbl[k]));
        return r;
    endfunction

    // monitor: every consumed result must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && m.out_valid && m.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out_f: result %0h delivered with nothing pending", m.out_f);
            end else chk("out_f", m.out_f, exp_q.pop_front());
        end
    end

    // one clock of the reference model: check visible state, then advance it past the edge
    task automatic step();
        bit acc, idle;
        @(negedge clk);
        idle = sw == 0 && !dn;
        chk("in_ready", m.in_ready, idle && !m.sweep_start && (!mv || m.out_ready));
        chk("out_valid", m.out_valid, mv);
        chk("busy", m.busy, sw != 0);
        chk("sweep_done", m.sweep_done, dn);
        if (sw == 0) chk("sweep_count", m.sweep_count, sc);
        if (mv && !m.out_ready) chk("out_f_hold", m.out_f, last_f);
        acc = m.in_valid && idle && !m.sweep_start && (!mv || m.out_ready);
        if (acc) begin
            last_f = eval_ref(m.in_vec);
            exp_q.push_back(last_f);
        end
        mv = acc || (mv && !m.out_ready);
        if (m.cfg_we && sw == 0 && int'(m.cfg_func) < NF) tbl[m.cfg_func] = m.cfg_table;
        if (dn) dn = 0;
        else if (sw > 0) begin
            sw--;
            if (sw == 0) begin
                dn = 1;
                sc = counts_ref();
            end
        end else if (m.sweep_start) begin
            sw = T;
            sc = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_busy", m.busy, 0);
        chk("rst_done", m.sweep_done, 0);
        chk("rst_count", m.sweep_count, 0);
        chk("rst_out_valid", m.out_valid, 0);
        chk("rst_out_f", m.out_f, 0);
        mv = 0;
        sw = 0;
        dn = 0;
        sc = '0;
        last_f = '0;
        exp_q.delete();
        for (int k = 0; k < NF; k++) tbl[k] = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic cfg(int f, logic [T-1:0] t);
        m.cfg_we = 1;
        m.cfg_func = 2'(f);
        m.cfg_table = t;
        step();
        m.cfg_we = 0;
    endtask

    initial begin
        int nb;
        bit got;
        logic [31:0] t5[4];
        logic [23:0] r5;
        logic [2:0] maj_vec[3] = '{3'b011, 3'b001, 3'b111};
        bit maj_exp[3] = '{1, 0, 1};
        {m.cfg_we, m.cfg_func, m.cfg_table, m.in_valid, m.in_vec, m.sweep_start} = '0;
        {p.cfg_we, p.cfg_func, p.cfg_table, p.in_valid, p.in_vec, p.sweep_start, p.out_ready} = '0;
        {q.cfg_we, q.cfg_func, q.cfg_table, q.in_valid, q.in_vec, q.sweep_start, q.out_ready} = '0;
        m.out_ready = 1;
        do_reset();
        cfg(0, 8'hE8);
        cfg(1, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            m.in_valid = 1;
            m.in_vec = maj_vec[i];
            step();
            m.in_valid = 0;
            chk("majority", m.out_f[0], maj_exp[i]);
            step();
        end
        m.in_valid = 1;
        for (int i = 0; i < T; i++) begin
            m.in_vec = NI'(i);
            step();
        end
        m.in_valid = 0;
        step();
        m.out_ready = 0;
        m.in_valid = 1;
        m.in_vec = 3'b011;
        step();
        m.in_vec = 3'b001;
        repeat (3) step();
        m.out_ready = 1;
        step();
        m.in_valid = 0;
        repeat (2) step();
        m.sweep_start = 1;
        step();
        m.sweep_start = 0;
        repeat (T + 2) step();
        chk("cnt_ch0", m.sweep_count[0 +: CW], 4);
        chk("cnt_ch1", m.sweep_count[CW +: CW], 8);
        m.cfg_we = 1;
        m.cfg_func = 0;
        m.cfg_table = 8'h00;
        m.in_valid = 1;
        m.in_vec = 3'b111;
        step();
        m.cfg_we = 0;
        chk("cfg_accept_old", m.out_f[0], 1);
        step();
        chk("cfg_accept_new", m.out_f[0], 0);
        m.in_vec = 3'b101;
        m.sweep_start = 1;
        step();
        m.sweep_start = 0;
        step();
        m.cfg_we = 1;
        m.cfg_func = 1;
        m.cfg_table = 8'h00;
        step();
        m.cfg_we = 0;
        repeat (T) step();
        m.in_valid = 0;
        step();
        chk("cfg_busy_ignored", m.sweep_count[CW +: CW], 8);
        for (int i = 0; i < 300; i++) begin
            m.in_valid = 1'($urandom_range(0, 1));
            m.in_vec = NI'($urandom);
            m.out_ready = $urandom_range(0, 3) != 0;
            m.cfg_we = $urandom_range(0, 5) == 0;
            m.cfg_func = 2'($urandom_range(0, 3));
            m.cfg_table = T'($urandom);
            m.sweep_start = $urandom_range(0, 40) == 0;
            step();
        end
        {m.cfg_we, m.in_valid, m.sweep_start} = '0;
        m.out_ready = 1;
        repeat (T + 3) step();
        cfg(0, 8'hA5);
        m.sweep_start = 1;
        step();
        m.sweep_start = 0;
        repeat (3) step();
        do_reset();
        m.in_valid = 1;
        for (int i = 0; i < T; i++) begin
            m.in_vec = NI'(i);
            step();
        end
        m.in_valid = 0;
        chk("post_rst_f", m.out_f, 0);
        m.sweep_start = 1;
        step();
        m.sweep_start = 0;
        repeat (T + 2) step();
        p.cfg_we = 1;
        p.cfg_table = 2'b10;
        @(posedge clk);
        #1;
        p.cfg_we = 0;
        p.sweep_start = 1;
        @(posedge clk);
        #1;
        p.sweep_start = 0;
        nb = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (p.busy) nb++;
            if (p.sweep_done) got = 1;
        end
        chk("p1_busy_cycles", nb, 2);
        chk("p1_done", got, 1);
        chk("p1_count", p.sweep_count, 1);
        r5 = '0;
        for (int k = 0; k < 4; k++) begin
            t5[k] = $urandom;
            r5[k*6 +: 6] = 6'($countones(t5[k]));
            @(posedge clk);
            #1;
            q.cfg_we = 1;
            q.cfg_func = 2'(k);
            q.cfg_table = t5[k];
        end
        @(posedge clk);
        #1;
        q.cfg_we = 0;
        q.sweep_start = 1;
        @(posedge clk);
        #1;
        q.sweep_start = 0;
        nb = 0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (q.busy) nb++;
            if (q.sweep_done) got = 1;
        end
        chk("p5_busy_cycles", nb, 32);
        chk("p5_done", got, 1);
        chk("p5_counts", q.sweep_count, r5);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
